// File: rtl/alu_issue_pkg.sv
// Shared constants, instruction field helpers and FSM state names for the
// ALU issue/writeback controller.
package alu_issue_pkg;

   // Opcode that is handled locally (load immediate) instead of going to the ALU.
   localparam logic [3:0] OP_LDI = 4'b1111;

   // Register file geometry; 3-bit register fields address 8 entries.
   localparam int NREGS  = 8;
   localparam int REG_W  = 8;
   localparam int ADDR_W = 3;

   // Instruction field positions (LSB of each field).
   localparam int OP_LSB  = 12;
   localparam int RD_LSB  = 9;
   localparam int RS1_LSB = 6;
   localparam int RS2_LSB = 3;
   localparam int IMM_LSB = 0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      SETTLE = 2'd2,
      WB     = 2'd3
   } state_e;

   function automatic logic [3:0] instr_op(input logic [15:0] w);
      return w[OP_LSB +: 4];
   endfunction

   function automatic logic [ADDR_W-1:0] instr_rd(input logic [15:0] w);
      return w[RD_LSB +: ADDR_W];
   endfunction

   function automatic logic [ADDR_W-1:0] instr_rs1(input logic [15:0] w);
      return w[RS1_LSB +: ADDR_W];
   endfunction

   function automatic logic [ADDR_W-1:0] instr_rs2(input logic [15:0] w);
      return w[RS2_LSB +: ADDR_W];
   endfunction

   function automatic logic [REG_W-1:0] instr_imm(input logic [15:0] w);
      return w[IMM_LSB +: REG_W];
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake plus the ALU8bit operand/result bus.
// master: instruction source and ALU side; slave: the issue controller.
interface alu_issue_ctrl_if;
   logic        instrValid;
   logic        instrReady;
   logic [15:0] instr;
   logic [3:0]  aluOpcode;
   logic [7:0]  aluOperand1;
   logic [7:0]  aluOperand2;
   logic [15:0] aluResult;
   logic        aluFlagC;
   logic        aluFlagZ;

   modport master (
      output instrValid, instr, aluResult, aluFlagC, aluFlagZ,
      input  instrReady, aluOpcode, aluOperand1, aluOperand2
   );

   modport slave (
      input  instrValid, instr, aluResult, aluFlagC, aluFlagZ,
      output instrReady, aluOpcode, aluOperand1, aluOperand2
   );
endinterface

// File: rtl/alu_regfile.sv
// 8x8 register file: one write port, two combinational read ports whose data
// the controller latches, and one combinational debug read port.
module alu_regfile
   import alu_issue_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [REG_W-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [REG_W-1:0]  rdata1,
   output logic [REG_W-1:0]  rdata2,
   output logic [REG_W-1:0]  dbg_data
);

   logic [REG_W-1:0] regs_w [NREGS];

   // Each register is a resettable flop so reset clears the whole file at once.
   for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      logic [REG_W-1:0] val_q;

      // Load wdata when this entry is addressed; reset clears it.
      always_ff @(posedge clk) begin
         if (rst) begin
            val_q <= '0;
         end else if (we && (waddr == ADDR_W'(gi))) begin
            val_q <= wdata;
         end
      end

      assign regs_w[gi] = val_q;
   end

   assign rdata1   = regs_w[raddr1];
   assign rdata2   = regs_w[raddr2];
   assign dbg_data = regs_w[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue controller in front of the combinational ALU8bit: accepts an
// instruction, presents registered operands, waits SETTLE_CYCLES, then writes
// the ALU result back. LDI is executed locally in the accept cycle.
module alu_issue_ctrl
   import alu_issue_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
)(
   input  logic                clk,
   input  logic                rst,
   alu_issue_ctrl_if.slave     bus,
   output logic                busy,
   output logic                done,
   output logic [7:0]          regHi,
   output logic                statusC,
   output logic                statusZ,
   input  logic [ADDR_W-1:0]   dbgAddr,
   output logic [REG_W-1:0]    dbgData
);

   localparam logic [1:0] S_IDLE   = 2'(IDLE);
   localparam logic [1:0] S_ISSUE  = 2'(ISSUE);
   localparam logic [1:0] S_SETTLE = 2'(SETTLE);
   localparam logic [1:0] S_WB     = 2'(WB);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   logic [1:0]        state_q, state_d;
   logic [15:0]       instr_q, instr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        opcode_q, opcode_d;
   logic [REG_W-1:0]  op1_q, op1_d;
   logic [REG_W-1:0]  op2_q, op2_d;
   logic [7:0]        hi_q, hi_d;
   logic              flag_c_q, flag_c_d;
   logic              flag_z_q, flag_z_d;
   logic              done_q, done_d;

   logic              instr_ready;
   logic              xfer;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [REG_W-1:0]  rf_wdata;
   logic [REG_W-1:0]  rf_rdata1;
   logic [REG_W-1:0]  rf_rdata2;
   logic              unused_instr_bits;

   // Low three instruction bits carry no field for register ops.
   assign unused_instr_bits = ^instr_q[2:0];

   assign instr_ready = (state_q == S_IDLE) && !rst;
   assign xfer        = bus.instrValid && instr_ready;

   // Read addresses come from the latched word; data is captured in ISSUE.
   alu_regfile u_regfile (
      .clk      (clk),
      .rst      (rst),
      .we       (rf_we),
      .waddr    (rf_waddr),
      .wdata    (rf_wdata),
      .raddr1   (instr_rs1(instr_q)),
      .raddr2   (instr_rs2(instr_q)),
      .dbg_addr (dbgAddr),
      .rdata1   (rf_rdata1),
      .rdata2   (rf_rdata2),
      .dbg_data (dbgData)
   );

   // Next-state logic, including the single write mux shared by LDI and writeback.
   always_comb begin
      state_d  = state_q;
      instr_d  = instr_q;
      cnt_d    = cnt_q;
      opcode_d = opcode_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      hi_d     = hi_q;
      flag_c_d = flag_c_q;
      flag_z_d = flag_z_q;
      done_d   = 1'b0;
      rf_we    = 1'b0;
      rf_waddr = instr_rd(bus.instr);
      rf_wdata = instr_imm(bus.instr);

      case (state_q)
         S_IDLE: begin
            if (xfer) begin
               instr_d = bus.instr;
               if (instr_op(bus.instr) == OP_LDI) begin
                  rf_we  = 1'b1;
                  done_d = 1'b1;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            opcode_d = instr_op(instr_q);
            op1_d    = rf_rdata1;
            op2_d    = rf_rdata2;
            cnt_d    = CNT_W'(SETTLE_CYCLES - 1);
            state_d  = S_SETTLE;
         end
         S_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = S_WB;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_WB: begin
            rf_we    = 1'b1;
            rf_waddr = instr_rd(instr_q);
            rf_wdata = bus.aluResult[7:0];
            hi_d     = bus.aluResult[15:8];
            flag_c_d = bus.aluFlagC;
            flag_z_d = bus.aluFlagZ;
            done_d   = 1'b1;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers; reset aborts any instruction in flight without writeback.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         instr_q  <= '0;
         cnt_q    <= '0;
         opcode_q <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         hi_q     <= '0;
         flag_c_q <= 1'b0;
         flag_z_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         instr_q  <= instr_d;
         cnt_q    <= cnt_d;
         opcode_q <= opcode_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         hi_q     <= hi_d;
         flag_c_q <= flag_c_d;
         flag_z_q <= flag_z_d;
         done_q   <= done_d;
      end
   end

   assign bus.instrReady  = instr_ready;
   assign bus.aluOpcode   = opcode_q;
   assign bus.aluOperand1 = op1_q;
   assign bus.aluOperand2 = op2_q;
   assign busy            = (state_q != S_IDLE);
   assign done            = done_q;
   assign regHi           = hi_q;
   assign statusC         = flag_c_q;
   assign statusZ         = flag_z_q;

endmodule
